// File: rtl/headlight_pkg.sv
// rtl/headlight_pkg.sv - state encoding, default levels and ramp step helpers
//
// Shared by headlight_fade_sequencer and automatic_headlight_control.
// Contents:
//   fade_state_e      OFF=0, FADE_IN=1, ON=2, FADE_OUT=3 (matches the 2-bit state port)
//   DEF_* constants   default timing, level and speed threshold values
//   step_toward()     move a level one step toward a target, never overshooting
//   step_down()       move a level one step toward zero, never wrapping
package headlight_pkg;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_FADE_IN  = 2'd1,
      ST_ON       = 2'd2,
      ST_FADE_OUT = 2'd3
   } fade_state_e;

   localparam int DEF_DEBOUNCE_CYCLES   = 4;
   localparam int DEF_OFF_DELAY_CYCLES  = 8;
   localparam int DEF_RAMP_STEP         = 32;
   localparam int DEF_LOW_BEAM_LEVEL    = 128;
   localparam int DEF_RAIN_LEVEL        = 192;
   localparam int DEF_HIGH_BEAM_LEVEL   = 255;
   localparam int DEF_HIGH_SPEED_THRESH = 80;

   // 9-bit sums/limits so that e.g. 224+32 clamps at the target instead of wrapping to 0.
   function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                              input logic [7:0] tgt,
                                              input logic [7:0] step);
      logic [8:0] up_sum;
      logic [8:0] down_lim;
      up_sum   = {1'b0, cur} + {1'b0, step};
      down_lim = {1'b0, tgt} + {1'b0, step};
      if (cur < tgt) begin
         return (up_sum > {1'b0, tgt}) ? tgt : up_sum[7:0];
      end else if ({1'b0, cur} < down_lim) begin
         return tgt;
      end else begin
         return cur - step;
      end
   endfunction

   function automatic logic [7:0] step_down(input logic [7:0] cur,
                                            input logic [7:0] step);
      return (cur < step) ? 8'd0 : (cur - step);
   endfunction

endpackage

// File: rtl/headlight_fade_sequencer_if.sv
// rtl/headlight_fade_sequencer_if.sv - sensor inputs and lamp outputs of the fade sequencer
//
// master: the side that drives sensors/tick and observes the lamp outputs
// slave : the sequencer itself
//   tick, ignition, light_sensor, rain_sensor, speed_sensor[7:0]  master -> slave
//   headlights, dim_level[7:0], state[1:0], busy                  slave -> master
interface headlight_fade_sequencer_if;

   logic       tick;
   logic       ignition;
   logic       light_sensor;
   logic       rain_sensor;
   logic [7:0] speed_sensor;
   logic       headlights;
   logic [7:0] dim_level;
   logic [1:0] state;
   logic       busy;

   modport master (
      output tick, ignition, light_sensor, rain_sensor, speed_sensor,
      input  headlights, dim_level, state, busy
   );

   modport slave (
      input  tick, ignition, light_sensor, rain_sensor, speed_sensor,
      output headlights, dim_level, state, busy
   );

endinterface

// File: rtl/headlight_debounce.sv
// rtl/headlight_debounce.sv - single-bit sensor debouncer
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   raw         unfiltered sensor bit
//   filtered    follows raw once raw has differed for DEBOUNCE_CYCLES consecutive edges
// Parameters:
//   DEBOUNCE_CYCLES  edges of disagreement needed before filtered flips (>=1)
//   RESET_VALUE      value of filtered while in reset
module headlight_debounce #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filtered
);

   // The counter never holds DEBOUNCE_CYCLES itself: the edge that would reach it flips instead.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filtered <= RESET_VALUE;
         cnt      <= '0;
      end else if (raw == filtered) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         filtered <= raw;
         cnt      <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/headlight_fade_sequencer.sv
// rtl/headlight_fade_sequencer.sv - debounced headlight on/off sequencing with ramped dim level
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         headlight_fade_sequencer_if.slave
//                 tick          one dim step allowed per cycle with tick=1
//                 ignition      car on (not debounced)
//                 light_sensor  raw ambient light, 1 = daylight
//                 rain_sensor   raw rain detect, 1 = raining
//                 speed_sensor  vehicle speed, unsigned
//                 headlights    lamp enable (registered)
//                 dim_level     lamp intensity (registered)
//                 state         OFF/FADE_IN/ON/FADE_OUT (registered)
//                 busy          ramping indicator (combinational)
module headlight_fade_sequencer
   import headlight_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int OFF_DELAY_CYCLES  = DEF_OFF_DELAY_CYCLES,
   parameter int RAMP_STEP         = DEF_RAMP_STEP,
   parameter int LOW_BEAM_LEVEL    = DEF_LOW_BEAM_LEVEL,
   parameter int RAIN_LEVEL        = DEF_RAIN_LEVEL,
   parameter int HIGH_BEAM_LEVEL   = DEF_HIGH_BEAM_LEVEL,
   parameter int HIGH_SPEED_THRESH = DEF_HIGH_SPEED_THRESH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   headlight_fade_sequencer_if.slave   bus
);

   localparam logic [7:0] STEP     = 8'(RAMP_STEP);
   localparam logic [7:0] LOW_LVL  = 8'(LOW_BEAM_LEVEL);
   localparam logic [7:0] RAIN_LVL = 8'(RAIN_LEVEL);
   localparam logic [7:0] HIGH_LVL = 8'(HIGH_BEAM_LEVEL);
   localparam logic [7:0] THRESH   = 8'(HIGH_SPEED_THRESH);

   localparam int HW = (OFF_DELAY_CYCLES > 1) ? $clog2(OFF_DELAY_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(OFF_DELAY_CYCLES - 1);

   logic          light_f;
   logic          rain_f;
   logic          need;
   logic [7:0]    target;

   fade_state_e   state_q, state_d;
   logic [7:0]    dim_q, dim_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          headlights_q;

   // Light resets to "daylight" so the lamps stay off until night is confirmed.
   headlight_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b1)
   ) u_light_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (bus.light_sensor),
      .filtered (light_f)
   );

   headlight_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (1'b0)
   ) u_rain_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (bus.rain_sensor),
      .filtered (rain_f)
   );

   assign need = bus.ignition & (~light_f | rain_f);

   always_comb begin
      if (rain_f) begin
         target = RAIN_LVL;
      end else if (bus.speed_sensor >= THRESH) begin
         target = HIGH_LVL;
      end else begin
         target = LOW_LVL;
      end
   end

   always_comb begin
      state_d = state_q;
      dim_d   = dim_q;
      hold_d  = hold_q;
      case (state_q)
         ST_OFF: begin
            dim_d = 8'd0;
            if (need) begin
               state_d = ST_FADE_IN;
            end
         end
         ST_FADE_IN: begin
            // Losing demand wins over the ramp: no step on the turnaround cycle.
            if (!need) begin
               state_d = ST_FADE_OUT;
            end else begin
               if (dim_q == target) begin
                  state_d = ST_ON;
               end
               if (bus.tick) begin
                  dim_d = step_toward(dim_q, target, STEP);
               end
            end
         end
         ST_ON: begin
            // Keep tracking target changes (speed, rain) while lit.
            if (bus.tick) begin
               dim_d = step_toward(dim_q, target, STEP);
            end
            if (!bus.ignition) begin
               state_d = ST_FADE_OUT;
               hold_d  = '0;
            end else if (need) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               state_d = ST_FADE_OUT;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         ST_FADE_OUT: begin
            if (need) begin
               state_d = ST_FADE_IN;
            end else if (dim_q == 8'd0) begin
               state_d = ST_OFF;
            end else if (bus.tick) begin
               dim_d = step_down(dim_q, STEP);
            end
         end
         default: begin
            state_d = ST_OFF;
            dim_d   = 8'd0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         dim_q        <= 8'd0;
         hold_q       <= '0;
         headlights_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dim_q        <= dim_d;
         hold_q       <= hold_d;
         headlights_q <= (state_d != ST_OFF);
      end
   end

   assign bus.state      = state_q;
   assign bus.dim_level  = dim_q;
   assign bus.headlights = headlights_q;
   assign bus.busy       = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT) ||
                           ((state_q == ST_ON) && (dim_q != target));

endmodule
